// File: rtl/prio_dispatch_pkg.sv
// Shared definitions for the priority dispatcher: command codes, slot state
// encoding and command classification helpers.
package prio_dispatch_pkg;

  localparam int CMD_W = 4;
  localparam int TAG_W = 2;

  localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
  localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
  localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
  localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    PEND_ADD = 2'd1,
    PEND_SHF = 2'd2
  } slot_state_e;

  function automatic logic is_add(input logic [CMD_W-1:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB);
  endfunction

  function automatic logic is_shf(input logic [CMD_W-1:0] cmd);
    return (cmd == CMD_SHL) || (cmd == CMD_SHR);
  endfunction

  function automatic logic is_valid(input logic [CMD_W-1:0] cmd);
    return is_add(cmd) || is_shf(cmd);
  endfunction

endpackage

// File: rtl/prio_dispatch_if.sv
// Bundle of hold-register inputs, execution-unit issue channels and response
// flags around the dispatcher; master is the dispatcher, slave its environment.
interface prio_dispatch_if #(
  parameter int NUM_PORTS = 4,
  parameter int DW        = 32
);
  import prio_dispatch_pkg::*;

  logic [4*NUM_PORTS-1:0]  hold_prio_req;
  logic [DW*NUM_PORTS-1:0] hold_data1;
  logic [DW*NUM_PORTS-1:0] hold_data2;

  // Issue channels: a transfer happens on a rising clock edge where vld and
  // rdy are both 1. Once vld rises, cmd/op1/op2/tag hold stable until that
  // transfer; vld never drops without one (except on reset).
  logic             add_vld;
  logic             add_rdy;
  logic [CMD_W-1:0] add_cmd;
  logic [DW-1:0]    add_op1;
  logic [DW-1:0]    add_op2;
  logic [TAG_W-1:0] add_tag;

  logic             shf_vld;
  logic             shf_rdy;
  logic [CMD_W-1:0] shf_cmd;
  logic [DW-1:0]    shf_op1;
  logic [DW-1:0]    shf_op2;
  logic [TAG_W-1:0] shf_tag;

  logic [NUM_PORTS-1:0] inv_cmd;
  logic [NUM_PORTS-1:0] port_drop;

  slot_state_e [NUM_PORTS-1:0] slot_dbg;

  modport master (
    input  hold_prio_req, hold_data1, hold_data2, add_rdy, shf_rdy,
    output add_vld, add_cmd, add_op1, add_op2, add_tag,
    output shf_vld, shf_cmd, shf_op1, shf_op2, shf_tag,
    output inv_cmd, port_drop, slot_dbg
  );

  modport slave (
    output hold_prio_req, hold_data1, hold_data2, add_rdy, shf_rdy,
    input  add_vld, add_cmd, add_op1, add_op2, add_tag,
    input  shf_vld, shf_cmd, shf_op1, shf_op2, shf_tag,
    input  inv_cmd, port_drop, slot_dbg
  );

endinterface

// File: rtl/prio_dispatch_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins; next_ptr points
// one past the winner. N must be a power of two so the index wraps for free.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] next_ptr,
  output logic          any
);

  logic [PW-1:0] idx;

  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    any      = 1'b0;
    idx      = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + PW'(i);
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        next_ptr   = idx + PW'(1);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_dispatch.sv
// Buffers one command per port, arbitrates round-robin per execution-unit
// class and issues to the adder and shifter over valid/ready channels.
module prio_dispatch
  import prio_dispatch_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DW        = 32
) (
  input  logic          c_clk,
  input  logic          reset,
  prio_dispatch_if.master bus
);

  localparam int PW = TAG_W;

  slot_state_e [NUM_PORTS-1:0] state_q, state_d;
  logic [CMD_W-1:0] cmd_q [NUM_PORTS];
  logic [DW-1:0]    op1_q [NUM_PORTS];
  logic [DW-1:0]    op2_q [NUM_PORTS];

  logic [NUM_PORTS-1:0] add_req, shf_req;
  logic [NUM_PORTS-1:0] add_grant, shf_grant;
  logic [NUM_PORTS-1:0] freed, capture, inv_d, drop_d;
  logic [NUM_PORTS-1:0] inv_q, drop_q;
  logic [PW-1:0]        add_ptr_q, shf_ptr_q, add_ptr_nxt, shf_ptr_nxt;
  logic                 add_any, shf_any, add_load, shf_load;
  logic [CMD_W-1:0]     c_in;

  logic             add_vld_q, shf_vld_q;
  logic [CMD_W-1:0] add_cmd_q, shf_cmd_q, add_sel_cmd, shf_sel_cmd;
  logic [DW-1:0]    add_op1_q, add_op2_q, shf_op1_q, shf_op2_q;
  logic [DW-1:0]    add_sel_op1, add_sel_op2, shf_sel_op1, shf_sel_op2;
  logic [TAG_W-1:0] add_tag_q, shf_tag_q, add_sel_tag, shf_sel_tag;

  always_comb begin
    add_req = '0;
    shf_req = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      add_req[p] = (state_q[p] == PEND_ADD);
      shf_req[p] = (state_q[p] == PEND_SHF);
    end
  end

  rr_arbiter #(.N(NUM_PORTS), .PW(PW)) u_add_arb (
    .req      (add_req),
    .ptr      (add_ptr_q),
    .grant    (add_grant),
    .next_ptr (add_ptr_nxt),
    .any      (add_any)
  );

  rr_arbiter #(.N(NUM_PORTS), .PW(PW)) u_shf_arb (
    .req      (shf_req),
    .ptr      (shf_ptr_q),
    .grant    (shf_grant),
    .next_ptr (shf_ptr_nxt),
    .any      (shf_any)
  );

  // An issue register takes a new winner when empty or draining this cycle.
  assign add_load = add_any && (!add_vld_q || bus.add_rdy);
  assign shf_load = shf_any && (!shf_vld_q || bus.shf_rdy);
  assign freed    = (add_load ? add_grant : '0) | (shf_load ? shf_grant : '0);

  // Slot FSM next state; a slot freed this cycle can accept a new command.
  always_comb begin
    state_d = state_q;
    capture = '0;
    inv_d   = '0;
    drop_d  = '0;
    c_in    = CMD_NOP;
    for (int p = 0; p < NUM_PORTS; p++) begin
      c_in = bus.hold_prio_req[4*p +: 4];
      if (freed[p]) state_d[p] = EMPTY;
      if (c_in != CMD_NOP) begin
        if (!is_valid(c_in)) begin
          inv_d[p] = 1'b1;
        end else if (state_q[p] == EMPTY || freed[p]) begin
          capture[p] = 1'b1;
          state_d[p] = is_add(c_in) ? PEND_ADD : PEND_SHF;
        end else begin
          drop_d[p] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_q <= {NUM_PORTS{EMPTY}};
      inv_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      inv_q   <= inv_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        cmd_q[p] <= CMD_NOP;
        op1_q[p] <= '0;
        op2_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (capture[p]) begin
          cmd_q[p] <= bus.hold_prio_req[4*p +: 4];
          op1_q[p] <= bus.hold_data1[DW*p +: DW];
          op2_q[p] <= bus.hold_data2[DW*p +: DW];
        end
      end
    end
  end

  // Grants are one-hot, so OR-ing the selected slots forms the issue mux.
  always_comb begin
    add_sel_cmd = '0;
    add_sel_op1 = '0;
    add_sel_op2 = '0;
    add_sel_tag = '0;
    shf_sel_cmd = '0;
    shf_sel_op1 = '0;
    shf_sel_op2 = '0;
    shf_sel_tag = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (add_grant[p]) begin
        add_sel_cmd = add_sel_cmd | cmd_q[p];
        add_sel_op1 = add_sel_op1 | op1_q[p];
        add_sel_op2 = add_sel_op2 | op2_q[p];
        add_sel_tag = add_sel_tag | TAG_W'(p);
      end
      if (shf_grant[p]) begin
        shf_sel_cmd = shf_sel_cmd | cmd_q[p];
        shf_sel_op1 = shf_sel_op1 | op1_q[p];
        shf_sel_op2 = shf_sel_op2 | op2_q[p];
        shf_sel_tag = shf_sel_tag | TAG_W'(p);
      end
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      add_vld_q <= 1'b0;
      add_cmd_q <= '0;
      add_op1_q <= '0;
      add_op2_q <= '0;
      add_tag_q <= '0;
      add_ptr_q <= '0;
    end else if (add_load) begin
      add_vld_q <= 1'b1;
      add_cmd_q <= add_sel_cmd;
      add_op1_q <= add_sel_op1;
      add_op2_q <= add_sel_op2;
      add_tag_q <= add_sel_tag;
      add_ptr_q <= add_ptr_nxt;
    end else if (bus.add_rdy) begin
      add_vld_q <= 1'b0;
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      shf_vld_q <= 1'b0;
      shf_cmd_q <= '0;
      shf_op1_q <= '0;
      shf_op2_q <= '0;
      shf_tag_q <= '0;
      shf_ptr_q <= '0;
    end else if (shf_load) begin
      shf_vld_q <= 1'b1;
      shf_cmd_q <= shf_sel_cmd;
      shf_op1_q <= shf_sel_op1;
      shf_op2_q <= shf_sel_op2;
      shf_tag_q <= shf_sel_tag;
      shf_ptr_q <= shf_ptr_nxt;
    end else if (bus.shf_rdy) begin
      shf_vld_q <= 1'b0;
    end
  end

  assign bus.add_vld   = add_vld_q;
  assign bus.add_cmd   = add_cmd_q;
  assign bus.add_op1   = add_op1_q;
  assign bus.add_op2   = add_op2_q;
  assign bus.add_tag   = add_tag_q;
  assign bus.shf_vld   = shf_vld_q;
  assign bus.shf_cmd   = shf_cmd_q;
  assign bus.shf_op1   = shf_op1_q;
  assign bus.shf_op2   = shf_op2_q;
  assign bus.shf_tag   = shf_tag_q;
  assign bus.inv_cmd   = inv_q;
  assign bus.port_drop = drop_q;
  assign bus.slot_dbg  = state_q;

endmodule
